// File: rtl/draw_cmd_dispatcher.sv
// draw_cmd_dispatcher
//   Pops draw commands from the command FIFO and hands each one to exactly one
//   draw engine, selected by the opcode in the top OP_WIDTH bits of the word.
//   Only one command is in flight at a time. The next pop waits until the
//   active engine reports done. Commands with an unknown opcode are dropped.
//   A timeout recovers from a FIFO read or an engine that never answers.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   ff_empty     FIFO empty flag
//   ff_rden      FIFO pop request (combinational, only asserted in IDLE)
//   ff_rdat      FIFO read data, qualified by ff_rvld
//   ff_rvld      FIFO read data valid
//   eng_vld      one-hot single-cycle start pulse, one bit per engine
//   eng_cmd      last dispatched command word, held until the next dispatch
//   eng_done     engine completion pulses, one bit per engine
//   busy         high whenever a command is being fetched or executed
//   err_unknown  single-cycle pulse: command dropped for an illegal opcode
//   err_timeout  single-cycle pulse: FIFO read or engine timed out
//   cmd_cnt      number of successful dispatches, wraps at 16 bits
module draw_cmd_dispatcher #(
  parameter int CMD_WIDTH = 32,
  parameter int OP_WIDTH  = 4,
  parameter int NUM_ENG   = 2,
  parameter int TO_WIDTH  = 16,
  parameter logic [TO_WIDTH-1:0] TIMEOUT_MAX = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ff_empty,
  output logic                 ff_rden,
  input  logic [CMD_WIDTH-1:0] ff_rdat,
  input  logic                 ff_rvld,
  output logic [NUM_ENG-1:0]   eng_vld,
  output logic [CMD_WIDTH-1:0] eng_cmd,
  input  logic [NUM_ENG-1:0]   eng_done,
  output logic                 busy,
  output logic                 err_unknown,
  output logic                 err_timeout,
  output logic [15:0]          cmd_cnt
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, BUSY} state_t;

  state_t                state, state_nxt;
  logic [TO_WIDTH-1:0]   to_cnt, to_cnt_nxt;
  logic [NUM_ENG-1:0]    eng_sel;     // one-hot copy of the active opcode
  logic [NUM_ENG-1:0]    op_hot;
  logic [OP_WIDTH-1:0]   op_in;
  logic                  op_legal;
  logic                  done_hit;
  logic                  dispatch;
  logic [NUM_ENG-1:0]    vld_nxt;
  logic                  unk_nxt;
  logic                  tmo_nxt;

  assign op_in    = ff_rdat[CMD_WIDTH-1 -: OP_WIDTH];
  // Opcode is zero-extended before comparing against the engine count.
  assign op_legal = (32'(op_in) < NUM_ENG);
  // Only the active engine's done bit counts; the others are masked off.
  assign done_hit = |(eng_done & eng_sel);
  assign busy     = (state != IDLE);

  always_comb begin
    op_hot = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      op_hot[i] = (32'(op_in) == 32'(i));
    end
  end

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    ff_rden    = 1'b0;
    dispatch   = 1'b0;
    vld_nxt    = '0;
    unk_nxt    = 1'b0;
    tmo_nxt    = 1'b0;
    case (state)
      IDLE: begin
        ff_rden = ~ff_empty & ~rst;
        if (ff_rden) begin
          state_nxt  = RD_WAIT;
          to_cnt_nxt = '0;
        end
      end
      RD_WAIT: begin
        to_cnt_nxt = to_cnt + TO_WIDTH'(1);
        if (ff_rvld) begin
          if (op_legal) begin
            dispatch   = 1'b1;
            vld_nxt    = op_hot;
            state_nxt  = BUSY;
            to_cnt_nxt = '0;
          end else begin
            unk_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (to_cnt == TIMEOUT_MAX) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        to_cnt_nxt = to_cnt + TO_WIDTH'(1);
        // Done takes priority over a timeout landing on the same cycle.
        if (done_hit) begin
          state_nxt = IDLE;
        end else if (to_cnt == TIMEOUT_MAX) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      eng_sel     <= '0;
      eng_vld     <= '0;
      eng_cmd     <= '0;
      err_unknown <= 1'b0;
      err_timeout <= 1'b0;
      cmd_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      to_cnt      <= to_cnt_nxt;
      eng_vld     <= vld_nxt;
      err_unknown <= unk_nxt;
      err_timeout <= tmo_nxt;
      if (dispatch) begin
        eng_cmd <= ff_rdat;
        eng_sel <= op_hot;
        cmd_cnt <= cmd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_draw_cmd_dispatcher.sv
// tb_draw_cmd_dispatcher
//   Directed bench for draw_cmd_dispatcher. One instance uses the default
//   timeout and is fed by a small FIFO model; a second instance uses a short
//   timeout and a constant-data read port for the timeout cases.
module tb_draw_cmd_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default-timeout instance
  logic        ff_empty, ff_rden, ff_rvld;
  logic [31:0] ff_rdat, eng_cmd;
  logic [1:0]  eng_vld, eng_done;
  logic        busy, err_unknown, err_timeout;
  logic [15:0] cmd_cnt;

  // Short-timeout instance
  logic        ff_empty_t, ff_rden_t, ff_rvld_t, hold_rvld_t;
  logic [31:0] ff_rdat_t, eng_cmd_t;
  logic [1:0]  eng_vld_t, eng_done_t;
  logic        busy_t, err_unknown_t, err_timeout_t;
  logic [15:0] cmd_cnt_t;

  int checks = 0;
  int errors = 0;

  draw_cmd_dispatcher dut (
    .clk(clk), .rst(rst),
    .ff_empty(ff_empty), .ff_rden(ff_rden), .ff_rdat(ff_rdat), .ff_rvld(ff_rvld),
    .eng_vld(eng_vld), .eng_cmd(eng_cmd), .eng_done(eng_done),
    .busy(busy), .err_unknown(err_unknown), .err_timeout(err_timeout),
    .cmd_cnt(cmd_cnt)
  );

  draw_cmd_dispatcher #(.TIMEOUT_MAX(16'd15)) dut_t (
    .clk(clk), .rst(rst),
    .ff_empty(ff_empty_t), .ff_rden(ff_rden_t), .ff_rdat(ff_rdat_t), .ff_rvld(ff_rvld_t),
    .eng_vld(eng_vld_t), .eng_cmd(eng_cmd_t), .eng_done(eng_done_t),
    .busy(busy_t), .err_unknown(err_unknown_t), .err_timeout(err_timeout_t),
    .cmd_cnt(cmd_cnt_t)
  );

  // FIFO model: data returned with valid one cycle after the pop
  logic [31:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign ff_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!rst && ff_rden) begin
      ff_rdat <= fifo_mem[rd_ptr[3:0]];
      rd_ptr  <= rd_ptr + 1;
      ff_rvld <= 1'b1;
    end else begin
      ff_rvld <= 1'b0;
    end
  end

  always @(posedge clk) begin
    ff_rvld_t <= ff_rden_t & ~rst & ~hold_rvld_t;
    ff_rdat_t <= 32'h0000_0055;
  end

  task automatic push(input logic [31:0] d);
    fifo_mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] rect_cmd;
  logic [1:0]  last_vld;
  int          first_vld, second_vld;

  initial begin
    rect_cmd    = {4'h1, 5'd10, 5'd10, 5'd20, 5'd14, 8'hAA};
    rst         = 1'b1;
    eng_done    = '0;
    eng_done_t  = '0;
    ff_empty_t  = 1'b1;
    hold_rvld_t = 1'b0;

    // Reset with a non-empty FIFO
    push(32'h0230_F000);
    tick(2);
    check_eq("rst_rden", 32'(ff_rden), 0);
    check_eq("rst_vld", 32'(eng_vld), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_cmd", eng_cmd, 0);
    check_eq("rst_cnt", 32'(cmd_cnt), 0);
    check_eq("rst_err", 32'({err_unknown, err_timeout}), 0);
    rst = 1'b0;
    #1;
    check_eq("rel_rden", 32'(ff_rden), 1);

    // Pixel command, done 20 cycles after the start pulse
    tick();
    check_eq("px_rdwait_busy", 32'(busy), 1);
    check_eq("px_rdwait_rden", 32'(ff_rden), 0);
    tick();
    check_eq("px_vld", 32'(eng_vld), 32'h1);
    check_eq("px_cmd", eng_cmd, 32'h0230_F000);
    check_eq("px_cnt", 32'(cmd_cnt), 1);
    tick();
    check_eq("px_vld_pulse", 32'(eng_vld), 0);
    tick(19);
    eng_done = 2'b01;
    check_eq("px_busy", 32'(busy), 1);
    tick();
    eng_done = 2'b00;
    check_eq("px_idle", 32'(busy), 0);
    check_eq("px_cnt_end", 32'(cmd_cnt), 1);
    check_eq("px_no_tmo", 32'(err_timeout), 0);

    // Rectangle command, foreign done ignored, own done after 100 cycles
    push(rect_cmd);
    #1;
    check_eq("rc_rden", 32'(ff_rden), 1);
    tick(2);
    check_eq("rc_vld", 32'(eng_vld), 32'h2);
    check_eq("rc_cmd", eng_cmd, rect_cmd);
    check_eq("rc_cnt", 32'(cmd_cnt), 2);
    tick();
    eng_done = 2'b01;
    tick();
    eng_done = 2'b00;
    check_eq("rc_foreign_done", 32'(busy), 1);
    tick(98);
    eng_done = 2'b10;
    tick();
    eng_done = 2'b00;
    check_eq("rc_idle", 32'(busy), 0);
    check_eq("rc_cnt_end", 32'(cmd_cnt), 2);

    // Unknown opcode followed by a pixel command
    push(32'h7000_00AB);
    push(32'h0000_1234);
    tick(2);
    check_eq("uk_err", 32'(err_unknown), 1);
    check_eq("uk_no_vld", 32'(eng_vld), 0);
    check_eq("uk_idle", 32'(busy), 0);
    check_eq("uk_cnt", 32'(cmd_cnt), 2);
    check_eq("uk_cmd_held", eng_cmd, rect_cmd);
    check_eq("uk_next_pop", 32'(ff_rden), 1);
    tick();
    check_eq("uk_err_pulse", 32'(err_unknown), 0);
    tick();
    check_eq("uk_px_vld", 32'(eng_vld), 32'h1);
    check_eq("uk_px_cmd", eng_cmd, 32'h0000_1234);
    check_eq("uk_px_cnt", 32'(cmd_cnt), 3);
    eng_done = 2'b01;              // done in the start-pulse cycle
    tick();
    eng_done = 2'b00;
    check_eq("uk_px_idle", 32'(busy), 0);

    // Short timeout: engine never answers
    ff_empty_t = 1'b0;
    #1;
    check_eq("to_rden", 32'(ff_rden_t), 1);
    tick();
    check_eq("to_rdwait_rden", 32'(ff_rden_t), 0);
    tick();
    check_eq("to_vld", 32'(eng_vld_t), 32'h1);
    check_eq("to_cnt1", 32'(cmd_cnt_t), 1);
    tick(15);
    check_eq("to_last_busy", 32'(busy_t), 1);
    check_eq("to_no_err_yet", 32'(err_timeout_t), 0);
    tick();
    check_eq("to_err", 32'(err_timeout_t), 1);
    check_eq("to_idle", 32'(busy_t), 0);
    check_eq("to_next_pop", 32'(ff_rden_t), 1);
    tick();
    ff_empty_t = 1'b1;
    check_eq("to_err_pulse", 32'(err_timeout_t), 0);
    tick();
    check_eq("to_vld2", 32'(eng_vld_t), 32'h1);
    check_eq("to_cnt2", 32'(cmd_cnt_t), 2);
    tick(15);
    eng_done_t = 2'b01;            // done on the final tolerated count
    tick();
    eng_done_t = 2'b00;
    check_eq("to_done_wins", 32'(err_timeout_t), 0);
    check_eq("to_done_idle", 32'(busy_t), 0);

    // Short timeout: read data never arrives
    hold_rvld_t = 1'b1;
    ff_empty_t  = 1'b0;
    tick();
    ff_empty_t  = 1'b1;
    tick(15);
    check_eq("rt_busy", 32'(busy_t), 1);
    check_eq("rt_no_err_yet", 32'(err_timeout_t), 0);
    tick();
    check_eq("rt_err", 32'(err_timeout_t), 1);
    check_eq("rt_idle", 32'(busy_t), 0);
    check_eq("rt_cnt", 32'(cmd_cnt_t), 2);

    // Back-to-back commands with one-cycle engines, reset during 2nd BUSY
    push(32'h0000_0001);
    push(32'h1000_0002);
    push(32'h0000_0003);
    last_vld   = '0;
    first_vld  = -1;
    second_vld = -1;
    for (int c = 0; c < 20 && second_vld < 0; c++) begin
      tick();
      eng_done = last_vld;
      last_vld = eng_vld;
      if (eng_vld != 2'b00) begin
        if (first_vld < 0) first_vld = c;
        else second_vld = c;
      end
    end
    check_eq("bb_spacing", 32'(second_vld - first_vld), 4);
    check_eq("bb_vld2", 32'(last_vld), 32'h2);
    check_eq("bb_cnt", 32'(cmd_cnt), 5);
    eng_done = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    check_eq("bb_rst_busy", 32'(busy), 0);
    check_eq("bb_rst_cnt", 32'(cmd_cnt), 0);
    check_eq("bb_rst_cmd", eng_cmd, 0);
    check_eq("bb_rst_vld", 32'(eng_vld), 0);
    check_eq("bb_rst_err", 32'({err_unknown, err_timeout}), 0);
    check_eq("bb_rst_rden", 32'(ff_rden), 0);
    rst = 1'b0;
    #1;
    check_eq("bb_rel_rden", 32'(ff_rden), 1);
    tick(2);
    check_eq("bb_third_vld", 32'(eng_vld), 32'h1);
    check_eq("bb_third_cmd", eng_cmd, 32'h0000_0003);
    check_eq("bb_third_cnt", 32'(cmd_cnt), 1);
    eng_done = 2'b01;
    tick();
    eng_done = 2'b00;
    check_eq("bb_third_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
